// File: rtl/wb_pkg.sv
// Shared types for the integer writeback arbiter.
// Slot layout, source encoding and default starvation limit.
package wb_pkg;

  localparam int WB_ADDR_W       = 5;
  localparam int WB_DATA_W       = 64;
  localparam int WB_STARVE_LIMIT = 3;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LSU  = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_slot_t;

endpackage

// File: rtl/wb_slot.sv
// One-entry result buffer for a single writeback source.
// Accepts on valid/ready, drops x0 writes, frees itself when granted.
module wb_slot
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_W,
  parameter int DATA_WIDTH = WB_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  grant,
  output wb_slot_t              slot
);

  logic fire;
  logic keep;

  // Free when empty, or when the held entry leaves this cycle.
  assign in_ready = !slot.valid | grant;
  assign fire     = in_valid & in_ready;
  assign keep     = in_rd != '0;

  // Load on handshake (x0 absorbed), otherwise clear on grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
    end else if (fire && keep) begin
      slot.valid <= 1'b1;
      slot.rd    <= WB_ADDR_W'(in_rd);
      slot.data  <= WB_DATA_W'(in_data);
    end else if (grant) begin
      slot.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter for the integer register file write port.
// LSU wins by default; the ALU wins after STARVE_LIMIT lost rounds.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH   = WB_ADDR_W,
  parameter int DATA_WIDTH   = WB_DATA_W,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_dataD,
  output logic                  busy
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  wb_slot_t             alu_slot;
  wb_slot_t             lsu_slot;
  wb_src_e              sel;
  logic                 grant_alu;
  logic                 grant_lsu;
  logic [CW-1:0]        starve_cnt;
  logic [WB_ADDR_W-1:0] win_rd;
  logic [WB_DATA_W-1:0] win_data;

  wb_slot #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu_slot (
    .clk      (clk),
    .rst      (rst),
    .in_valid (alu_valid),
    .in_ready (alu_ready),
    .in_rd    (alu_rd),
    .in_data  (alu_data),
    .grant    (grant_alu),
    .slot     (alu_slot)
  );

  wb_slot #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lsu_slot (
    .clk      (clk),
    .rst      (rst),
    .in_valid (lsu_valid),
    .in_ready (lsu_ready),
    .in_rd    (lsu_rd),
    .in_data  (lsu_data),
    .grant    (grant_lsu),
    .slot     (lsu_slot)
  );

  // Pick the source to write back this cycle.
  always_comb begin
    sel = WB_NONE;
    if (lsu_slot.valid && starve_cnt < LIM) begin
      sel = WB_LSU;
    end else if (alu_slot.valid) begin
      sel = WB_ALU;
    end
  end

  assign grant_lsu = sel == WB_LSU;
  assign grant_alu = sel == WB_ALU;

  // Steer the winning slot onto the write bus.
  always_comb begin
    win_rd   = '0;
    win_data = '0;
    unique case (1'b1)
      grant_lsu: begin
        win_rd   = lsu_slot.rd;
        win_data = lsu_slot.data;
      end
      grant_alu: begin
        win_rd   = alu_slot.rd;
        win_data = alu_slot.data;
      end
      default: begin
        win_rd   = '0;
        win_data = '0;
      end
    endcase
  end

  // Count rounds the waiting ALU entry loses to the LSU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!alu_slot.valid || grant_alu) begin
      starve_cnt <= '0;
    end else if (grant_lsu && starve_cnt < LIM) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Registered write port; index and data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wen   <= 1'b0;
      rf_rd    <= '0;
      rf_dataD <= '0;
    end else begin
      rf_wen <= grant_lsu | grant_alu;
      if (grant_lsu | grant_alu) begin
        rf_rd    <= ADDR_WIDTH'(win_rd);
        rf_dataD <= DATA_WIDTH'(win_data);
      end
    end
  end

  assign busy = alu_slot.valid | lsu_slot.valid | rf_wen;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for the writeback arbiter.
// Hand-computed expectations for each scenario.
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_data;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [63:0] rf_dataD;
  logic        busy;

  int checks = 0;
  int errors = 0;

  wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .rf_wen    (rf_wen),
    .rf_rd     (rf_rd),
    .rf_dataD  (rf_dataD),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic       fire;
  logic [4:0] s_rd [6];
  logic       s_rdy [6];

  initial begin
    s_rd  = '{5'd1, 5'd2, 5'd3, 5'd7, 5'd4, 5'd5};
    s_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    rst = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    step();
    step();
    chk("rst_wen", rf_wen, 0);
    chk("rst_rd", rf_rd, 0);
    chk("rst_data", rf_dataD, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_rdy", alu_ready, 1);
    chk("rst_lsu_rdy", lsu_ready, 1);
    rst = 1'b0;
    step();

    // single ALU write
    alu_valid = 1; alu_rd = 5; alu_data = 64'h1234;
    step();
    alu_valid = 0;
    chk("alu1_wen_e0", rf_wen, 0);
    chk("alu1_busy_e0", busy, 1);
    step();
    chk("alu1_wen", rf_wen, 1);
    chk("alu1_rd", rf_rd, 5);
    chk("alu1_data", rf_dataD, 64'h1234);
    step();
    chk("alu1_wen_off", rf_wen, 0);
    chk("alu1_busy_off", busy, 0);
    chk("alu1_rd_hold", rf_rd, 5);

    // simultaneous sources
    alu_valid = 1; alu_rd = 3; alu_data = 64'hAA;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 64'hBB;
    step();
    alu_valid = 0; lsu_valid = 0;
    chk("sim_alu_rdy", alu_ready, 0);
    chk("sim_lsu_rdy", lsu_ready, 1);
    step();
    chk("sim_wen1", rf_wen, 1);
    chk("sim_rd1", rf_rd, 4);
    chk("sim_data1", rf_dataD, 64'hBB);
    step();
    chk("sim_wen2", rf_wen, 1);
    chk("sim_rd2", rf_rd, 3);
    chk("sim_data2", rf_dataD, 64'hAA);
    step();
    chk("sim_wen_off", rf_wen, 0);

    // x0 filter
    alu_valid = 1; alu_rd = 0; alu_data = 64'hFFFF;
    chk("x0_rdy", alu_ready, 1);
    step();
    alu_valid = 0;
    chk("x0_busy", busy, 0);
    chk("x0_wen", rf_wen, 0);
    step();
    chk("x0_wen2", rf_wen, 0);
    chk("x0_busy2", busy, 0);

    // starvation guard
    alu_valid = 1; alu_rd = 7; alu_data = 64'h77;
    lsu_valid = 1; lsu_rd = 1; lsu_data = 64'h101;
    step();
    alu_valid = 0;
    lsu_rd = 2; lsu_data = 64'h102;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("stv_rdy%0d", k), lsu_ready, s_rdy[k]);
      fire = lsu_ready;
      step();
      if (fire) begin
        lsu_rd   = lsu_rd + 1'b1;
        lsu_data = 64'h100 + 64'(lsu_rd);
      end
      chk($sformatf("stv_wen%0d", k), rf_wen, 1);
      chk($sformatf("stv_rd%0d", k), rf_rd, s_rd[k]);
      if (k == 3) chk("stv_alu_data", rf_dataD, 64'h77);
      if (k == 4) chk("stv_lsu_data", rf_dataD, 64'h104);
    end
    lsu_valid = 0;
    step();
    chk("stv_tail_rd", rf_rd, 6);
    chk("stv_tail_wen", rf_wen, 1);
    step();
    chk("stv_idle", rf_wen, 0);
    chk("stv_busy", busy, 0);

    // back-to-back LSU
    lsu_valid = 1; lsu_rd = 1; lsu_data = 64'h201;
    for (int i = 1; i <= 10; i++) begin
      if (i <= 8) chk($sformatf("b2b_rdy%0d", i), lsu_ready, 1);
      step();
      if (i < 8) begin
        lsu_rd   = 5'(i + 1);
        lsu_data = 64'h200 + 64'(i + 1);
      end else begin
        lsu_valid = 0;
      end
      if (i >= 2 && i <= 9) begin
        chk($sformatf("b2b_wen%0d", i), rf_wen, 1);
        chk($sformatf("b2b_rd%0d", i), rf_rd, 5'(i - 1));
      end
      if (i == 10) chk("b2b_off", rf_wen, 0);
    end

    // async reset with both slots full
    alu_valid = 1; alu_rd = 9;  alu_data = 64'h99;
    lsu_valid = 1; lsu_rd = 10; lsu_data = 64'hA0;
    step();
    alu_valid = 0; lsu_valid = 0;
    chk("pre_rst_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_wen", rf_wen, 0);
    chk("ar_rd", rf_rd, 0);
    chk("ar_data", rf_dataD, 0);
    chk("ar_busy", busy, 0);
    chk("ar_alu_rdy", alu_ready, 1);
    chk("ar_lsu_rdy", lsu_ready, 1);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("ar_post_wen%0d", i), rf_wen, 0);
      chk($sformatf("ar_post_busy%0d", i), busy, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that drives the write port of the integer register file. It accepts results from the single-cycle ALU path and the multi-cycle load/store unit through valid/ready handshakes, buffers one result per source, and arbitrates them onto a single registered write port (`rf_wen`/`rf_rd`/`rf_dataD`). LSU has priority, with a starvation guard for the ALU. Writes to x0 are absorbed.

## Interface
- `ADDR_WIDTH`, 5, register index width
- `DATA_WIDTH`, 64, register data width
- `STARVE_LIMIT`, 3, consecutive lost arbitrations after which the ALU wins
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `alu_valid`  in  1  ALU result valid
- `alu_ready`  out  1  arbiter can accept an ALU result
- `alu_rd`  in  ADDR_WIDTH  ALU destination register
- `alu_data`  in  DATA_WIDTH  ALU result
- `lsu_valid`, `lsu_ready`, `lsu_rd`, `lsu_data`: same as the ALU ports, for the LSU
- `rf_wen`  out  1  register-file write enable (registered)
- `rf_rd`  out  ADDR_WIDTH  write index (registered)
- `rf_dataD`  out  DATA_WIDTH  write data (registered)
- `busy`  out  1  any slot valid or `rf_wen` high

## Operation
- **Slots.** Each source has one slot holding `{valid, rd, data}`.
- **Ready.** `x_ready = !slot_valid | grant_x`. Ready is combinational from slot state and the grant only; it never depends on `x_valid`.
- **Handshake.** A transfer occurs when `x_valid & x_ready` at a rising edge. The slot loads `rd`/`data`.
- **x0 writes.** If the incoming `rd == 0`, the transfer completes but the slot is not loaded. No write is ever issued for x0.
- **Arbitration.** Combinational, each cycle, over valid slots:
  - LSU slot valid and `starve_cnt < STARVE_LIMIT`: grant LSU.
  - Otherwise, if the ALU slot is valid: grant ALU.
  - At most one grant per cycle.
- **Grant.** The granted slot is cleared at the edge. At the same edge the output registers load `rf_wen=1`, `rf_rd=slot.rd`, `rf_dataD=slot.data`.
- **No grant.** `rf_wen` loads 0. `rf_rd`/`rf_dataD` hold their previous values.
- **Starvation counter `starve_cnt`.** Width is `$clog2(STARVE_LIMIT+1)`.
  - Increments when the ALU slot is valid and LSU is granted.
  - Clears on an ALU grant, or when the ALU slot is empty.
  - Saturates at `STARVE_LIMIT`.
- **Refill on grant.** A slot granted in a cycle can accept a new transfer at the same edge. Back-to-back throughput is one result per source per cycle only while that source keeps winning.
- **Ordering.**
  - Per-source order is preserved.
  - Cross-source ordering to the same `rd` is grant order. The issue logic must not have two in-flight writes to the same `rd` from different sources.
- **Reset.**
  - Asynchronous reset clears both slots, `starve_cnt`, `rf_wen`, `rf_rd`, and `rf_dataD` to 0.
  - In-flight results are dropped.
  - While `rst` is high, `alu_ready` and `lsu_ready` are 1 (slots empty), but no transfer is captured.

## Timing
- **Reset values.** `rf_wen=0`, `rf_rd=0`, `rf_dataD=0`, `busy=0`, `alu_ready=1`, `lsu_ready=1`.
- **Latency.**
  - Transfer at edge E0.
  - Grant in the cycle after E0.
  - `rf_wen` high in the cycle after E1.
  - Register file writes at E2.
- **`rf_wen` width.** High for exactly one cycle per granted result.
- **Both sources valid with empty slots.**
  - Both transfer at E0.
  - LSU written out at E1, ALU at E2.
  - `alu_ready` is low in the cycle after E0, so a second ALU result waits.
- **LSU streaming every cycle with ALU pending.** LSU gets `STARVE_LIMIT` grants, then ALU gets one grant. LSU is back-pressured (`lsu_ready=0`) during that cycle.

## Structure
- **Shared package `wb_pkg`.**
  - `wb_src_e` enum: `WB_NONE`, `WB_ALU`, `WB_LSU`.
  - Slot struct typedef `{valid, rd, data}`.
  - Default `STARVE_LIMIT`.
- **Sub-module `wb_slot`.**
  - One-entry buffer with handshake, x0 filter and clear-on-grant.
  - Instantiated twice.
  - Top level holds the arbiter, the counter and the output registers.

## Test plan
- **Reset.** Assert `rst` mid-cycle with both slots full → outputs go to 0 immediately, both readys are 1, and no `rf_wen` follows after release.
- **Single ALU write.** ALU transfers `rd=5`, `data=0x1234` at E0 → `rf_wen=1`, `rf_rd=5`, `rf_dataD=0x1234` for exactly one cycle after E1. `busy` then drops.
- **Simultaneous sources.** ALU `rd=3`/`0xAA` and LSU `rd=4`/`0xBB` transfer at E0 → `rd=4` written at E1, `rd=3` at E2. `alu_ready=0` in the cycle after E0.
- **Starvation guard.** LSU valid every cycle (`rd=1..`) with one ALU result `rd=7` pending → three LSU writes, then `rd=7`, then LSU resumes. `lsu_ready=0` in the ALU-grant cycle.
- **x0 filter.** ALU transfers `rd=0`, `data=0xFFFF` → handshake completes, `rf_wen` stays 0, `busy` stays 0.
- **Back-to-back single source.** LSU streams `rd=1..8` with no ALU traffic → eight consecutive `rf_wen` cycles in order, and `lsu_ready` stays 1 throughout.
